// File: rtl/conbus_pkg.sv
// Shared types, bus widths and round-robin helper for conbus_rr.
// Optional watchdog is enabled by defining CONBUS_RR_TIMEOUT_EN.
package conbus_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  // First requester scanning upward from last+1, wrapping at nm.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] req,
    input logic [2:0] last,
    input int         nm
  );
    logic [2:0] g;
    logic       found;
    int         idx;
    g     = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = (int'(last) + i) % nm;
      if (i <= nm && !found && req[idx[2:0]]) begin
        g     = idx[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/conbus_rr_if.sv
// Bus bundle between masters, the conbus_rr switch and slaves.
// Optional watchdog is enabled by defining CONBUS_RR_TIMEOUT_EN.
interface conbus_rr_if
  import conbus_pkg::*;
#(
  parameter int NM = 6,
  parameter int NS = 6
) ();

  logic [NM*WB_AW-1:0] m_adr_i;
  logic [NM*WB_DW-1:0] m_dat_i;
  logic [WB_DW-1:0]    m_dat_o;
  logic [NM*3-1:0]     m_cti_i;
  logic [NM*4-1:0]     m_sel_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0]       m_cyc_i;
  logic [NM-1:0]       m_stb_i;
  logic [NM-1:0]       m_ack_o;
  logic [NM-1:0]       m_err_o;

  logic [WB_AW-1:0]    s_adr_o;
  logic [WB_DW-1:0]    s_dat_o;
  logic [2:0]          s_cti_o;
  logic [3:0]          s_sel_o;
  logic                s_we_o;
  logic [NS*WB_DW-1:0] s_dat_i;
  logic [NS-1:0]       s_cyc_o;
  logic [NS-1:0]       s_stb_o;
  logic [NS-1:0]       s_ack_i;

  // Switch side.
  modport slave (
    input  m_adr_i, m_dat_i, m_cti_i, m_sel_i,
    input  m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_cti_o, s_sel_o,
    output s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

  // Environment side: masters and slaves.
  modport master (
    output m_adr_i, m_dat_i, m_cti_i, m_sel_i,
    output m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_cti_o, s_sel_o,
    input  s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i
  );

endinterface

// File: rtl/conbus_rr_arb.sv
// Registered round-robin arbiter: grant held until owner drops cyc.
// Optional watchdog is enabled by defining CONBUS_RR_TIMEOUT_EN.
module conbus_rr_arb
  import conbus_pkg::*;
#(
  parameter int NM = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NM-1:0] req_i,
  output logic [NM-1:0] gnt_o,
  output logic          owned_o
);

  localparam logic [2:0] LAST_RST = 3'(NM - 1);

  arb_state_e state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] last_q, last_d;
  logic [7:0] req;

  always_comb begin
    req          = '0;
    req[NM-1:0]  = req_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Leaving OWNED always lands in IDLE: one dead cycle per handover.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(req, last_q, NM);
          last_d  = gnt_d;
          state_d = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (!req[gnt_q]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign owned_o = (state_q == ARB_OWNED);

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NM; k++) begin
      gnt_o[k] = owned_o && (gnt_q == 3'(k));
    end
  end

endmodule

// File: rtl/conbus_rr.sv
// N-master / M-slave Wishbone shared-bus switch with round-robin grant.
// Define CONBUS_RR_TIMEOUT_EN to add the silent-slave watchdog.
module conbus_rr
  import conbus_pkg::*;
#(
  parameter int                      NM       = 6,
  parameter int                      NS       = 6,
  parameter int                      S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0]  S_ADDR   = '0,
  parameter int                      TIMEOUT  = 1023
) (
  input  logic sys_clk,
  input  logic sys_rst,
  conbus_rr_if.slave bus
);

  logic [NM-1:0]    gnt;
  logic             owned;

  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] dat;
  logic [2:0]       cti;
  logic [3:0]       sel;
  logic             we;
  logic             cyc_g;
  logic             stb_g;

  logic [NS-1:0]    sel_s;
  logic             hit;
  logic             ack_s;
  logic [WB_DW-1:0] rdat;

  logic             err_q, err_d;
  logic             to_fire;

  conbus_rr_arb #(.NM(NM)) u_arb (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .req_i   (bus.m_cyc_i),
    .gnt_o   (gnt),
    .owned_o (owned)
  );

  // gnt is all-zero while idle, so the shared bus idles at 0.
  always_comb begin
    adr   = '0;
    dat   = '0;
    cti   = CTI_CLASSIC;
    sel   = '0;
    we    = 1'b0;
    cyc_g = 1'b0;
    stb_g = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gnt[k]) begin
        adr   = bus.m_adr_i[k*WB_AW +: WB_AW];
        dat   = bus.m_dat_i[k*WB_DW +: WB_DW];
        cti   = bus.m_cti_i[k*3 +: 3];
        sel   = bus.m_sel_i[k*4 +: 4];
        we    = bus.m_we_i[k];
        cyc_g = bus.m_cyc_i[k];
        stb_g = bus.m_stb_i[k];
      end
    end
  end

  always_comb begin
    sel_s = '0;
    hit   = 1'b0;
    rdat  = '0;
    for (int i = 0; i < NS; i++) begin
      if (!hit &&
          adr[WB_AW-1 -: S_ADDR_W] ==
          S_ADDR[i*S_ADDR_W +: S_ADDR_W]) begin
        hit      = 1'b1;
        sel_s[i] = 1'b1;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (sel_s[i]) rdat = bus.s_dat_i[i*WB_DW +: WB_DW];
    end
  end

  assign ack_s = |(sel_s & bus.s_ack_i);

`ifdef CONBUS_RR_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    to_fire = 1'b0;
    if (!owned || ack_s || err_q) begin
      cnt_d = '0;
    end else if (stb_g) begin
      if (cnt_q == 10'(TIMEOUT - 1)) begin
        to_fire = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign to_fire = 1'b0 & (TIMEOUT != 0);
`endif

  // Error is a one-cycle pulse; a still-pending stb re-arms it.
  assign err_d = owned & stb_g & ~err_q & (~hit | to_fire);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bus.s_adr_o = adr;
  assign bus.s_dat_o = dat;
  assign bus.s_cti_o = cti;
  assign bus.s_sel_o = sel;
  assign bus.s_we_o  = we;

  assign bus.s_cyc_o = (owned & cyc_g & ~err_q) ? sel_s : '0;
  assign bus.s_stb_o = (owned & stb_g & ~err_q) ? sel_s : '0;

  assign bus.m_ack_o = (owned & ack_s & ~err_q) ? gnt : '0;
  assign bus.m_err_o = err_q ? gnt : '0;
  assign bus.m_dat_o = owned ? rdat : '0;

endmodule

// File: tb/tb_conbus_rr.sv
// Directed bench for conbus_rr with grant-order scoreboard.
// Timeout checks follow CONBUS_RR_TIMEOUT_EN.
module tb_conbus_rr;
  import conbus_pkg::*;

  localparam int NM = 6;
  localparam int NS = 6;
  localparam logic [17:0] TAGS =
    {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};
`ifdef CONBUS_RR_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic sys_clk;
  logic sys_rst;
  int   total;
  int   bad;
  int   hold;
  int   cur;
  int   first;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [5:0]  errv;
  logic [5:0]  cycv;

  conbus_rr_if #(.NM(NM), .NS(NS)) bus ();

  conbus_rr #(
    .NM(NM), .NS(NS), .S_ADDR_W(3),
    .S_ADDR(TAGS), .TIMEOUT(TO)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int k, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic [2:0] cti, input logic we);
    bus.m_adr_i[k*32 +: 32] = adr;
    bus.m_dat_i[k*32 +: 32] = dat;
    bus.m_sel_i[k*4 +: 4]   = sel;
    bus.m_cti_i[k*3 +: 3]   = cti;
    bus.m_we_i[k]           = we;
  endtask

  task automatic drop_all();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.s_ack_i = '0;
    step();
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sys_rst = 1'b1;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_cti_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.s_ack_i = '0;
    for (int i = 0; i < NS; i++)
      bus.s_dat_i[i*32 +: 32] = 32'hA000_0000 | i;
    for (int k = 0; k < NM; k++)
      set_m(k, 32'(k*16), 32'h5500_0000 | k, 4'hF, CTI_INCR, 1'b0);
    repeat (3) step();

    chk("rst_s_cyc", bus.s_cyc_o, 0);
    chk("rst_s_stb", bus.s_stb_o, 0);
    chk("rst_ack",   bus.m_ack_o, 0);
    chk("rst_err",   bus.m_err_o, 0);
    chk("rst_dat",   bus.m_dat_o, 0);

    // Masters 0 and 1 request the cycle after reset falls.
    sys_rst = 1'b0;
    step();
    bus.m_cyc_i = 6'b000011;
    bus.m_stb_i = 6'b000011;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h10);
    #1;
    chk("pre_grant", bus.s_cyc_o, 0);
    step();
    e = exp_q.pop_front();
    chk("first_gnt", bus.s_adr_o, e);
    chk("first_cyc", bus.s_cyc_o, 6'b000001);
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    step();
    chk("dead_cyc", bus.s_cyc_o, 0);
    step();
    e = exp_q.pop_front();
    chk("second_gnt", bus.s_adr_o, e);
    drop_all();

    // Round-robin among 0, 2, 5 from a fresh reset.
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h50);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h50);
    bus.m_cyc_i = 6'b100101;
    bus.m_stb_i = 6'b100101;
    hold = 0;
    cur  = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      if (bus.s_cyc_o != 0) begin
        if (hold == 0) begin
          e = exp_q.pop_front();
          chk("rr_order", bus.s_adr_o, e);
          cur = int'(bus.s_adr_o[6:4]);
        end
        hold++;
        if (hold == 2) begin
          bus.m_cyc_i[cur] = 1'b0;
          bus.m_stb_i[cur] = 1'b0;
          hold = 0;
        end
      end else begin
        bus.m_cyc_i = 6'b100101;
        bus.m_stb_i = 6'b100101;
      end
    end
    chk("rr_done", exp_q.size(), 0);
    drop_all();

    // Master 1 reads slave 2.
    set_m(1, 32'h4000_0010, 32'h1234_5678, 4'b0011, CTI_EOB, 1'b0);
    bus.s_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
    bus.s_ack_i  = 6'b000100;
    bus.m_cyc_i  = 6'b000010;
    bus.m_stb_i  = 6'b000010;
    step();
    chk("rd_s_cyc", bus.s_cyc_o, 6'b000100);
    chk("rd_s_stb", bus.s_stb_o, 6'b000100);
    chk("rd_ack",   bus.m_ack_o, 6'b000010);
    chk("rd_dat",   bus.m_dat_o, 32'hDEAD_BEEF);
    chk("rd_err",   bus.m_err_o, 0);
    chk("rd_wdat",  bus.s_dat_o, 32'h1234_5678);
    chk("rd_sel",   bus.s_sel_o, 4'b0011);
    chk("rd_cti",   bus.s_cti_o, CTI_EOB);
    chk("rd_we",    bus.s_we_o, 1'b0);
    drop_all();

    // Unmapped tag 3'b011.
    set_m(0, 32'h6000_0000, 32'h0, 4'hF, CTI_CLASSIC, 1'b1);
    bus.m_cyc_i = 6'b000001;
    bus.m_stb_i = 6'b000001;
    step();
    chk("um_cyc0", bus.s_cyc_o, 0);
    chk("um_err0", bus.m_err_o, 0);
    step();
    chk("um_err1", bus.m_err_o, 6'b000001);
    chk("um_ack1", bus.m_ack_o, 0);
    chk("um_cyc1", bus.s_cyc_o, 0);
    step();
    chk("um_err2", bus.m_err_o, 0);
    step();
    chk("um_refire", bus.m_err_o, 6'b000001);
    drop_all();

    // Reset while master 1 is mid-cycle to the SRAM.
    set_m(1, 32'h2000_0000, 32'h0, 4'hF, CTI_CLASSIC, 1'b0);
    set_m(0, 32'h0000_0040, 32'h0, 4'hF, CTI_CLASSIC, 1'b0);
    set_m(2, 32'h0000_0080, 32'h0, 4'hF, CTI_CLASSIC, 1'b0);
    bus.m_cyc_i = 6'b000010;
    bus.m_stb_i = 6'b000010;
    step();
    chk("sram_cyc", bus.s_cyc_o, 6'b000010);
    sys_rst = 1'b1;
    bus.m_cyc_i = 6'b000111;
    bus.m_stb_i = 6'b000111;
    step();
    chk("rst_drop", bus.s_cyc_o, 0);
    sys_rst = 1'b0;
    exp_q.push_back(32'h0000_0040);
    step();
    e = exp_q.pop_front();
    chk("rst_winner", bus.s_adr_o, e);
    drop_all();

    // Silent slave 3.
    set_m(2, 32'h8000_0000, 32'h0, 4'hF, CTI_CLASSIC, 1'b0);
    bus.m_cyc_i = 6'b000100;
    bus.m_stb_i = 6'b000100;
    step();
    chk("silent_stb", bus.s_stb_o, 6'b001000);
    first = -1;
    errv  = '0;
    cycv  = '1;
`ifdef CONBUS_RR_TIMEOUT_EN
    for (int i = 1; i <= 40; i++) begin
      step();
      if (first < 0 && bus.m_err_o != 0) begin
        first = i;
        errv  = bus.m_err_o;
        cycv  = bus.s_cyc_o;
      end
    end
    chk("to_cycle", first, 16);
    chk("to_err",   errv, 6'b000100);
    chk("to_kill",  cycv, 0);
`else
    for (int i = 1; i <= 2000; i++) begin
      step();
      if (first < 0 && bus.m_err_o != 0) first = i;
    end
    chk("no_timeout", first, -1);
    chk("stall_stb", bus.s_stb_o, 6'b001000);
`endif
    drop_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
